// File: rtl/move_controller_if.sv
// Move-request handshake and board RAM port of the Othello move controller.
// FLIP_COUNT_EN adds the flip_count result bus.
interface move_controller_if #(
  parameter int COORD_W = 3
);
  // new_move is a request sampled only while busy is low; every accepted
  // request is answered by exactly one single-cycle ack or nack pulse.
  logic                   new_move;
  logic                   player;
  logic [COORD_W-1:0]     cur_x;
  logic [COORD_W-1:0]     cur_y;
  logic [1:0]             mem_rdata;
  logic [2*COORD_W-1:0]   mem_addr;
  logic                   mem_we;
  logic [1:0]             mem_wdata;
  logic                   busy;
  logic                   ack;
  logic                   nack;
  logic [3:0]             state_dbg;
`ifdef FLIP_COUNT_EN
  logic [2*COORD_W-1:0]   flip_count;
`endif

  modport master (
    output new_move, player, cur_x, cur_y, mem_rdata,
    input  mem_addr, mem_we, mem_wdata, busy, ack, nack, state_dbg
`ifdef FLIP_COUNT_EN
    , input flip_count
`endif
  );

  modport slave (
    input  new_move, player, cur_x, cur_y, mem_rdata,
    output mem_addr, mem_we, mem_wdata, busy, ack, nack, state_dbg
`ifdef FLIP_COUNT_EN
    , output flip_count
`endif
  );
endinterface

// File: rtl/move_controller.sv
// Executes one Othello move on the board RAM: validate target, scan 8 rays,
// flip bracketed runs, place piece, ack/nack. FLIP_COUNT_EN adds flip_count.
module move_controller #(
  parameter int COORD_W = 3
) (
  input logic              clock,
  input logic              reset,
  move_controller_if.slave bus
);
  localparam int AW = 2 * COORD_W;

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_CHK_EV, S_DIR, S_RD, S_EV,
    S_FLIP, S_NEXT, S_PLACE, S_ACK, S_REJECT
  } state_t;

  // Step encoding per axis: 00 stay, 01 increment, 10 decrement.
  function automatic logic [3:0] dir_step(input logic [2:0] d);
    case (d)
      3'd0:    dir_step = {2'b00, 2'b10};
      3'd1:    dir_step = {2'b01, 2'b10};
      3'd2:    dir_step = {2'b01, 2'b00};
      3'd3:    dir_step = {2'b01, 2'b01};
      3'd4:    dir_step = {2'b00, 2'b01};
      3'd5:    dir_step = {2'b10, 2'b01};
      3'd6:    dir_step = {2'b10, 2'b00};
      default: dir_step = {2'b10, 2'b10};
    endcase
  endfunction

  function automatic logic can_step(input logic [COORD_W-1:0] c, input logic [1:0] s);
    case (s)
      2'b01:   can_step = (c != {COORD_W{1'b1}});
      2'b10:   can_step = (c != {COORD_W{1'b0}});
      default: can_step = 1'b1;
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] step_c(input logic [COORD_W-1:0] c, input logic [1:0] s);
    case (s)
      2'b01:   step_c = c + 1'b1;
      2'b10:   step_c = c - 1'b1;
      default: step_c = c;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               player_q, player_d;
  logic [2:0]         dir_q, dir_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
  logic [COORD_W-1:0] cnt_q, cnt_d, k_q, k_d;
  logic               any_flip_q, any_flip_d;
  logic [AW-1:0]      total_q, total_d;
  logic [AW-1:0]      addr_q, addr_d;
`ifdef FLIP_COUNT_EN
  logic [AW-1:0]      fc_q, fc_d;
`endif

  logic [1:0] sx, sy;
  logic [1:0] own_code, opp_code;
  logic       target_step_ok, pos_step_ok;
  logic       we, ack, nack;
  logic [1:0] wdata;

  assign {sx, sy}        = dir_step(dir_q);
  assign own_code        = player_q ? 2'b10 : 2'b01;
  assign opp_code        = player_q ? 2'b01 : 2'b10;
  assign target_step_ok  = can_step(x_q, sx) && can_step(y_q, sy);
  assign pos_step_ok     = can_step(px_q, sx) && can_step(py_q, sy);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      player_q   <= 1'b0;
      dir_q      <= '0;
      px_q       <= '0;
      py_q       <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      any_flip_q <= 1'b0;
      total_q    <= '0;
      addr_q     <= '0;
`ifdef FLIP_COUNT_EN
      fc_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      player_q   <= player_d;
      dir_q      <= dir_d;
      px_q       <= px_d;
      py_q       <= py_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      any_flip_q <= any_flip_d;
      total_q    <= total_d;
      addr_q     <= addr_d;
`ifdef FLIP_COUNT_EN
      fc_q       <= fc_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    player_d   = player_q;
    dir_d      = dir_q;
    px_d       = px_q;
    py_d       = py_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    any_flip_d = any_flip_q;
    total_d    = total_q;
    addr_d     = addr_q;
`ifdef FLIP_COUNT_EN
    fc_d       = fc_q;
`endif
    we         = 1'b0;
    wdata      = 2'b00;
    ack        = 1'b0;
    nack       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.new_move) begin
          x_d        = bus.cur_x;
          y_d        = bus.cur_y;
          player_d   = bus.player;
          any_flip_d = 1'b0;
          total_d    = '0;
          state_d    = S_CHK;
        end
      end
      S_CHK: begin
        addr_d  = {y_q, x_q};
        state_d = S_CHK_EV;
      end
      S_CHK_EV: begin
        if (bus.mem_rdata == 2'b01 || bus.mem_rdata == 2'b10) begin
          state_d = S_REJECT;
        end else begin
          dir_d   = '0;
          state_d = S_DIR;
        end
      end
      S_DIR: begin
        if (!target_step_ok) begin
          state_d = S_NEXT;
        end else begin
          px_d    = step_c(x_q, sx);
          py_d    = step_c(y_q, sy);
          cnt_d   = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        addr_d  = {py_q, px_q};
        state_d = S_EV;
      end
      S_EV: begin
        if (bus.mem_rdata == opp_code) begin
          cnt_d = cnt_q + 1'b1;
          if (pos_step_ok) begin
            px_d    = step_c(px_q, sx);
            py_d    = step_c(py_q, sy);
            state_d = S_RD;
          end else begin
            state_d = S_NEXT;
          end
        end else if (bus.mem_rdata == own_code && cnt_q != '0) begin
          // Rewind the pointer to the first cell next to the target.
          px_d    = step_c(x_q, sx);
          py_d    = step_c(y_q, sy);
          k_d     = {{(COORD_W-1){1'b0}}, 1'b1};
          state_d = S_FLIP;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_FLIP: begin
        addr_d = {py_q, px_q};
        we     = 1'b1;
        wdata  = own_code;
        if (k_q == cnt_q) begin
          any_flip_d = 1'b1;
          total_d    = total_q + {{COORD_W{1'b0}}, cnt_q};
          state_d    = S_NEXT;
        end else begin
          px_d = step_c(px_q, sx);
          py_d = step_c(py_q, sy);
          k_d  = k_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (dir_q == 3'd7) begin
          state_d = any_flip_q ? S_PLACE : S_REJECT;
        end else begin
          dir_d   = dir_q + 1'b1;
          state_d = S_DIR;
        end
      end
      S_PLACE: begin
        addr_d  = {y_q, x_q};
        we      = 1'b1;
        wdata   = own_code;
        state_d = S_ACK;
      end
      S_ACK: begin
        ack     = 1'b1;
`ifdef FLIP_COUNT_EN
        fc_d    = total_q;
`endif
        state_d = S_IDLE;
      end
      S_REJECT: begin
        nack    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_addr  = addr_d;
  assign bus.mem_we    = we;
  assign bus.mem_wdata = wdata;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ack       = ack;
  assign bus.nack      = nack;
  assign bus.state_dbg = state_q;
`ifdef FLIP_COUNT_EN
  assign bus.flip_count = fc_q;
`endif
endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: table of moves on preset boards plus
// hand sequences for response timing, busy-time requests and mid-move reset.
module tb_move_controller;
  logic clock;
  logic reset;
  logic load_req;
  int   board_sel;
  logic [1:0] ram [64];
  logic [7:0] wr_log[$];
  logic [5:0] rd_log[$];
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  move_controller_if #(.COORD_W(3)) bus();
  move_controller #(.COORD_W(3)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Board presets; index is {y,x}.
  function automatic logic [1:0] preset(input int sel, input int idx);
    int x, y;
    x = idx % 8;
    y = idx / 8;
    preset = 2'b00;
    case (sel)
      0: if ((x == 3 && y == 3) || (x == 4 && y == 4)) preset = 2'b10;
         else if ((x == 4 && y == 3) || (x == 3 && y == 4)) preset = 2'b01;
      1: if ((x == 3 && y == 3) || (x == 2 && y == 3)) preset = 2'b01;
         else if ((x == 4 && y == 4) || (x == 2 && y == 4)) preset = 2'b10;
      2: if (y == 0 && x >= 1 && x <= 5) preset = 2'b10;
         else if (y == 0 && x == 6) preset = 2'b01;
      3: if (y == 0 && x >= 1) preset = 2'b10;
      default: preset = 2'b00;
    endcase
  endfunction

  always @(posedge clock) begin
    if (load_req) begin
      for (int i = 0; i < 64; i++) ram[i] <= preset(board_sel, i);
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  always @(posedge clock) begin
    if (reset && bus.mem_we) wr_log.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.busy && !bus.mem_we) rd_log.push_back(bus.mem_addr);
  end

  typedef struct packed {
    int          board;
    int          x;
    int          y;
    logic        p;
    logic        exp_ack;
    int          n_wr;
    logic [47:0] wr;
    int          fc;
    int          n_rd;
    logic [23:0] rd;
  } vec_t;

  function automatic logic [7:0] wcell(input int a, input logic [1:0] d);
    wcell = {a[5:0], d};
  endfunction

  function automatic logic [5:0] rcell(input int a);
    rcell = a[5:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_board(input int sel);
    @(negedge clock);
    board_sel = sel;
    load_req  = 1'b1;
    @(negedge clock);
    load_req  = 1'b0;
    wr_log.delete();
    rd_log.delete();
  endtask

  // resp: 1 ack, 2 nack, 3 both, 4 pulse longer than a cycle, 0 timeout
  task automatic run_move(input int x, input int y, input logic p, output int resp);
    @(negedge clock);
    bus.new_move = 1'b1;
    bus.cur_x    = 3'(x);
    bus.cur_y    = 3'(y);
    bus.player   = p;
    @(negedge clock);
    bus.new_move = 1'b0;
    resp = 0;
    for (int c = 0; c < 400 && resp == 0; c++) begin
      if (bus.ack && bus.nack) resp = 3;
      else if (bus.ack) resp = 1;
      else if (bus.nack) resp = 2;
      if (resp == 0) @(negedge clock);
    end
    @(negedge clock);
    if (bus.ack || bus.nack) resp = 4;
  endtask

  vec_t vt[8];

  initial begin
    int resp, bad, early, wecnt, acks, nacks, n;
    logic [1:0] ev;
    logic [7:0] e;
    vec_t v;

    vt[0] = '{0, 3, 2, 1'b0, 1'b1, 2, {32'd0, wcell(19, 2'b01), wcell(27, 2'b01)}, 1, 0, 24'd0};
    vt[1] = '{0, 3, 3, 1'b0, 1'b0, 0, 48'd0, 1, 1, {18'd0, rcell(27)}};
    vt[2] = '{0, 0, 0, 1'b0, 1'b0, 0, 48'd0, 1, 4, {rcell(9), rcell(8), rcell(1), rcell(0)}};
    vt[3] = '{1, 2, 2, 1'b1, 1'b1, 3,
              {24'd0, wcell(18, 2'b10), wcell(26, 2'b10), wcell(27, 2'b10)}, 2, 0, 24'd0};
    vt[4] = '{0, 7, 7, 1'b0, 1'b0, 0, 48'd0, 2, 4, {rcell(54), rcell(62), rcell(55), rcell(63)}};
    vt[5] = '{0, 5, 3, 1'b1, 1'b1, 2, {32'd0, wcell(29, 2'b10), wcell(28, 2'b10)}, 1, 0, 24'd0};
    vt[6] = '{2, 0, 0, 1'b0, 1'b1, 6,
              {wcell(0, 2'b01), wcell(5, 2'b01), wcell(4, 2'b01),
               wcell(3, 2'b01), wcell(2, 2'b01), wcell(1, 2'b01)}, 5, 0, 24'd0};
    vt[7] = '{3, 0, 0, 1'b0, 1'b0, 0, 48'd0, 5, 0, 24'd0};

    reset = 1'b0;
    load_req = 1'b0;
    board_sel = 0;
    bus.new_move = 1'b0;
    bus.player = 1'b0;
    bus.cur_x = '0;
    bus.cur_y = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", bus.busy, 0);
    check("rst_ack_nack", {bus.ack, bus.nack}, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
`ifdef FLIP_COUNT_EN
    check("rst_flip_count", bus.flip_count, 0);
`endif
    reset = 1'b1;

    for (int t = 0; t < 8; t++) begin
      v = vt[t];
      load_board(v.board);
      for (int j = 0; j < v.n_wr; j++) exp_q.push_back(v.wr[j*8 +: 8]);
      run_move(v.x, v.y, v.p, resp);
      check($sformatf("resp_v%0d", t), resp, v.exp_ack ? 1 : 2);
      check($sformatf("wr_count_v%0d", t), wr_log.size(), exp_q.size());
      n = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (n < wr_log.size()) check($sformatf("wr_v%0d_%0d", t, n), wr_log[n], e);
        n++;
      end
      bad = 0;
      for (int i = 0; i < 64; i++) begin
        ev = preset(v.board, i);
        for (int j = 0; j < v.n_wr; j++)
          if (int'(v.wr[j*8+2 +: 6]) == i) ev = v.wr[j*8 +: 2];
        if (ram[i] !== ev) bad++;
      end
      check($sformatf("board_v%0d", t), bad, 0);
      if (v.n_rd > 0) begin
        bad = 0;
        foreach (rd_log[i]) begin
          int hit;
          hit = 0;
          for (int j = 0; j < v.n_rd; j++) if (rd_log[i] == v.rd[j*6 +: 6]) hit = 1;
          if (hit == 0) bad++;
        end
        for (int j = 0; j < v.n_rd; j++) begin
          int hit;
          hit = 0;
          foreach (rd_log[i]) if (rd_log[i] == v.rd[j*6 +: 6]) hit = 1;
          if (hit == 0) bad++;
        end
        check($sformatf("reads_v%0d", t), bad, 0);
      end
`ifdef FLIP_COUNT_EN
      check($sformatf("flip_count_v%0d", t), bus.flip_count, v.fc);
`endif
    end

    // Occupied target: nack shows in the third cycle counted from the sampling edge.
    load_board(0);
    @(negedge clock);
    bus.new_move = 1'b1;
    bus.cur_x = 3'd3;
    bus.cur_y = 3'd3;
    bus.player = 1'b0;
    @(negedge clock);
    bus.new_move = 1'b0;
    early = bus.nack;
    wecnt = bus.mem_we;
    @(negedge clock);
    early = early | bus.nack;
    wecnt = wecnt + bus.mem_we;
    @(negedge clock);
    wecnt = wecnt + bus.mem_we;
    check("occ_nack_early", early, 0);
    check("occ_nack_t3", bus.nack, 1);
    check("occ_we", wecnt, 0);
    @(negedge clock);
    check("occ_idle", bus.busy, 0);

    // Second request while busy must be dropped.
    load_board(0);
    @(negedge clock);
    bus.new_move = 1'b1;
    bus.cur_x = 3'd3;
    bus.cur_y = 3'd2;
    bus.player = 1'b0;
    @(negedge clock);
    bus.new_move = 1'b0;
    repeat (3) @(negedge clock);
    bus.new_move = 1'b1;
    bus.cur_x = 3'd0;
    bus.cur_y = 3'd0;
    bus.player = 1'b1;
    @(negedge clock);
    bus.new_move = 1'b0;
    acks = 0;
    nacks = 0;
    for (int c = 0; c < 300; c++) begin
      acks += int'(bus.ack);
      nacks += int'(bus.nack);
      @(negedge clock);
    end
    check("busy_req_acks", acks, 1);
    check("busy_req_nacks", nacks, 0);
    check("busy_req_writes", wr_log.size(), 2);

    // Reset during FLIP aborts silently; the next request runs normally.
    load_board(2);
    @(negedge clock);
    bus.new_move = 1'b1;
    bus.cur_x = 3'd0;
    bus.cur_y = 3'd0;
    bus.player = 1'b0;
    @(negedge clock);
    bus.new_move = 1'b0;
    n = 0;
    while (!bus.mem_we && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("flip_reached", bus.mem_we, 1);
    reset = 1'b0;
    @(negedge clock);
    check("abort_busy", bus.busy, 0);
    check("abort_ack_nack", {bus.ack, bus.nack}, 0);
    check("abort_we", bus.mem_we, 0);
`ifdef FLIP_COUNT_EN
    check("abort_flip_count", bus.flip_count, 0);
`endif
    reset = 1'b1;
    load_board(0);
    run_move(3, 2, 1'b0, resp);
    check("after_reset_resp", resp, 1);
    check("after_reset_writes", wr_log.size(), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
